// File: rtl/spi_master_tx.sv
// spi_master_tx: mode-0 SPI byte serialiser, MSB first; in: clk, reset, tx_valid/tx_data/tx_last stream; out: tx_ready, sck/mosi/cs, busy, done
`timescale 1ns/1ps
module spi_master_tx #(
  parameter int DIV      = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       sck,
  output logic       mosi,
  output logic       cs,
  output logic       busy,
  output logic       done
);
  localparam int DW = $clog2(DIV + 1);
  localparam int TW = $clog2((CS_SETUP > CS_GAP ? CS_SETUP : CS_GAP) + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, GAP} state_t;
  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      bit_cnt;
  logic [TW-1:0]   tmr;
  logic [7:0]      sh;
  logic            last;
  logic            hs;
  assign tx_ready = !reset && (state == IDLE || state == NEXT);
  assign hs       = tx_valid && tx_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tmr     <= '0;
      sh      <= '0;
      last    <= 1'b0;
      cs      <= 1'b1;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (hs) begin
          sh      <= tx_data;
          last    <= tx_last;
          cs      <= 1'b0;
          mosi    <= tx_data[7];
          tmr     <= TW'(CS_SETUP - 1);
          bit_cnt <= '0;
          busy    <= 1'b1;
          state   <= SETUP;
        end
        SETUP: if (tmr == '0) begin
          div_cnt <= '0;
          state   <= SHIFT;
        end else tmr <= tmr - 1'b1;
        SHIFT: if (div_cnt == DW'(DIV - 1)) begin
          div_cnt <= '0;
          sck     <= !sck;
          if (!sck) bit_cnt <= bit_cnt + 4'd1;
          else if (bit_cnt != 4'd8) begin
            mosi <= sh[6];
            sh   <= {sh[6:0], 1'b0};
          end else if (last) begin
            cs    <= 1'b1;
            mosi  <= 1'b0;
            done  <= 1'b1;
            tmr   <= TW'(CS_GAP - 1);
            state <= GAP;
          end else begin
            bit_cnt <= '0;
            state   <= NEXT;
          end
        end else div_cnt <= div_cnt + 1'b1;
        NEXT: if (hs) begin
          sh      <= tx_data;
          last    <= tx_last;
          mosi    <= tx_data[7];
          div_cnt <= '0;
          state   <= SHIFT;
        end
        GAP: if (tmr == '0) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else tmr <= tmr - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
